// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo read-side controller.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH      = 2;
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: captures fifo read data and presents the head word.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output occ_t                  o_occ,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_head;
  logic                  r_tail;
  occ_t                  r_occ;

  // Storage is not reset; r_occ gates visibility so stale entries never leak out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ~r_tail;
      end
      if (i_pop) r_head <= ~r_head;
      r_occ <= r_occ + occ_t'(i_push) - occ_t'(i_pop);
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = (r_occ != '0) ? r_mem[r_head] : '0;

endmodule

// File: rtl/fifo_reader.sv
// Drains the synchronous fifo into a valid/ready stream at one word per clock,
// hiding the fifo's one-cycle read latency behind a 2-entry buffer.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  read_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  busy
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_words;
  occ_t                 w_occ;
  logic                 w_pop;
  logic [2:0]           w_level;

  assign w_pop = out_valid & out_ready;

  // Projected occupancy after this edge; a read is only safe if a slot remains
  // for it once the in-flight word lands.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign read_en = enable & ~fifo_empty & ~reset & (w_level < 3'd2);

  fifo_reader_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (out_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_words    <= '0;
    end else begin
      r_inflight <= read_en;
      if (w_pop) r_words <= r_words + CNT_WIDTH'(1);
    end
  end

  assign out_valid  = (w_occ != '0);
  assign busy       = r_inflight | out_valid;
  assign words_read = r_words;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural one-cycle-latency fifo.
module tb_fifo_reader;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          read_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] words_read;
  logic          busy;

  logic [DW-1:0] fmem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            underflows = 0;
  logic [DW-1:0] rx [0:255];
  int            rx_cnt = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .read_en       (read_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .words_read    (words_read),
    .busy          (busy)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Fifo model: data appears one cycle after read_en; shares the DUT reset.
  always @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= wr_ptr;
      fifo_data_out <= '0;
    end else if (read_en) begin
      if (wr_ptr == rd_ptr) underflows <= underflows + 1;
      fifo_data_out <= fmem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) begin
      rx[rx_cnt[7:0]] <= out_data;
      rx_cnt          <= rx_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[7:0]] = first + DW'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || words_read !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b words=%0d data=%h, want 0 0 0 00",
               out_valid, busy, words_read, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (read_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || words_read !== '0) begin
        failures++;
        $display("FAIL empty_idle cyc%0d: rd=%b valid=%b busy=%b words=%0d, want all 0",
                 i, read_en, out_valid, busy, words_read);
      end
    end
  endtask

  task automatic test_stream();
    int            brx;
    int            errs;
    logic [CW-1:0] bw;
    brx = rx_cnt; bw = words_read; errs = 0;
    load(8'h01, 20);
    #1;
    checks++;
    if (read_en !== 1'b1) begin
      failures++;
      $display("FAIL stream_first_read: read_en=%b want 1", read_en);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_lat1: out_valid=%b want 0", out_valid);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      failures++;
      $display("FAIL stream_lat2: valid=%b data=%h want 1 01", out_valid, out_data);
    end
    tick(20);
    checks++;
    if (words_read !== bw + 16'd20 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stream_count: words=%0d busy=%b want %0d 0", words_read, busy, bw + 16'd20);
    end
    for (int i = 0; i < 20; i++)
      if (rx[(brx + i) % 256] !== 8'h01 + DW'(i)) errs++;
    checks++;
    if (errs != 0 || rx_cnt != brx + 20) begin
      failures++;
      $display("FAIL stream_order: bad=%0d got_words=%0d want 0 20", errs, rx_cnt - brx);
    end
  endtask

  task automatic test_backpressure();
    int brx;
    int brd;
    int errs;
    brx = rx_cnt; brd = rd_ptr; errs = 0;
    out_ready = 1'b0;
    load(8'hA0, 5);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
          failures++;
          $display("FAIL bp_hold cyc%0d: valid=%b data=%h want 1 a0", i, out_valid, out_data);
        end
      end
    end
    checks++;
    if (rd_ptr - brd != 2) begin
      failures++;
      $display("FAIL bp_reads: issued=%0d want 2", rd_ptr - brd);
    end
    out_ready = 1'b1;
    tick(12);
    for (int i = 0; i < 5; i++)
      if (rx[(brx + i) % 256] !== 8'hA0 + DW'(i)) errs++;
    checks++;
    if (errs != 0 || rx_cnt != brx + 5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: bad=%0d words=%0d busy=%b want 0 5 0", errs, rx_cnt - brx, busy);
    end
  endtask

  task automatic test_toggle();
    int brx;
    int brd;
    int lvl;
    int errs;
    int maxlvl;
    brx = rx_cnt; brd = rd_ptr; errs = 0; maxlvl = 0;
    load(8'h30, 12);
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      tick(1);
      lvl = (rd_ptr - brd) - (rx_cnt - brx);
      if (lvl > maxlvl) maxlvl = lvl;
    end
    checks++;
    if (maxlvl > 2) begin
      failures++;
      $display("FAIL toggle_level: max occ+inflight=%0d want <=2", maxlvl);
    end
    out_ready = 1'b1;
    tick(20);
    for (int i = 0; i < 12; i++)
      if (rx[(brx + i) % 256] !== 8'h30 + DW'(i)) errs++;
    checks++;
    if (errs != 0 || rx_cnt != brx + 12 || underflows != 0) begin
      failures++;
      $display("FAIL toggle_order: bad=%0d words=%0d underflows=%0d want 0 12 0",
               errs, rx_cnt - brx, underflows);
    end
  endtask

  task automatic test_enable_drop();
    int brx;
    brx = rx_cnt;
    enable = 1'b1; out_ready = 1'b1;
    load(8'h50, 3);
    #1;
    checks++;
    if (read_en !== 1'b1) begin
      failures++;
      $display("FAIL en_first_read: read_en=%b want 1", read_en);
    end
    tick(1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (read_en !== 1'b0) begin
        failures++;
        $display("FAIL en_off_read cyc%0d: read_en=%b want 0", i, read_en);
      end
      tick(1);
    end
    checks++;
    if (rx_cnt != brx + 1 || rx[brx % 256] !== 8'h50) begin
      failures++;
      $display("FAIL en_inflight: words=%0d first=%h want 1 50", rx_cnt - brx, rx[brx % 256]);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (read_en !== 1'b1) begin
      failures++;
      $display("FAIL en_resume: read_en=%b want 1", read_en);
    end
    tick(8);
    checks++;
    if (rx_cnt != brx + 3 || rx[(brx + 1) % 256] !== 8'h51 || rx[(brx + 2) % 256] !== 8'h52) begin
      failures++;
      $display("FAIL en_rest: words=%0d w1=%h w2=%h want 3 51 52",
               rx_cnt - brx, rx[(brx + 1) % 256], rx[(brx + 2) % 256]);
    end
  endtask

  task automatic test_reset_mid();
    int brx;
    enable = 1'b1; out_ready = 1'b0;
    load(8'h70, 5);
    tick(2);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || read_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre: valid=%b busy=%b rd=%b want 1 1 0", out_valid, busy, read_en);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || words_read !== '0 || read_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b busy=%b words=%0d rd=%b want 0 0 0 0",
               out_valid, busy, words_read, read_en);
    end
    brx = rx_cnt;
    out_ready = 1'b1;
    tick(4);
    checks++;
    if (rx_cnt != brx || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_stale: words=%0d valid=%b want 0 0", rx_cnt - brx, out_valid);
    end
    load(8'h90, 2);
    tick(8);
    checks++;
    if (rx_cnt != brx + 2 || rx[brx % 256] !== 8'h90 || rx[(brx + 1) % 256] !== 8'h91 ||
        words_read !== 16'd2) begin
      failures++;
      $display("FAIL mid_fresh: words=%0d w0=%h w1=%h cnt=%0d want 2 90 91 2",
               rx_cnt - brx, rx[brx % 256], rx[(brx + 1) % 256], words_read);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_enable_drop();
    test_reset_mid();
    checks++;
    if (underflows != 0) begin
      failures++;
      $display("FAIL underflow: reads_while_empty=%0d want 0", underflows);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
